// File: rtl/weighted_choose_n_if.sv
`timescale 1ns/1ps
`default_nettype none
//----------------------------------------------------------------------
// weighted_choose_n_if - request/result bundle for weighted_choose_n, rev 1.0
//----------------------------------------------------------------------
interface weighted_choose_n_if #(
  parameter int WIDTH   = 16,
  parameter int N_ITEMS = 8
);
  localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

  logic [31:0]              in_seed;
  logic                     in_start;
  logic [N_ITEMS*WIDTH-1:0] in_weights;
  logic                     out_busy;
  logic                     out_valid;
  logic [IDX_W-1:0]         out_segment_number;
  logic                     out_error;

  modport master (
    output in_seed, in_start, in_weights,
    input  out_busy, out_valid, out_segment_number, out_error
  );

  modport slave (
    input  in_seed, in_start, in_weights,
    output out_busy, out_valid, out_segment_number, out_error
  );
endinterface
`default_nettype wire

// File: rtl/weighted_choose_n.sv
`timescale 1ns/1ps
`default_nettype none
//----------------------------------------------------------------------
// weighted_choose_n - LFSR-driven weighted random item selector, rev 1.0
//----------------------------------------------------------------------
module weighted_choose_n #(
  parameter int WIDTH   = 16,
  parameter int N_ITEMS = 8
) (
  input  logic              in_clock,
  input  logic              in_reset,
  weighted_choose_n_if.slave bus
);
  localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int SUM_W = WIDTH + $clog2(N_ITEMS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_ITEMS - 1);
  localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SUM  = 3'd1,
    ST_DRAW = 3'd2,
    ST_SCAN = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] bank [N_ITEMS];
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] mask;
  logic [SUM_W-1:0] residual;
  logic [IDX_W-1:0] idx;
  logic [31:0]      lfsr;
  logic [IDX_W-1:0] seg;
  logic             err;

  logic [SUM_W-1:0] weight_ext;
  logic [SUM_W-1:0] sum_next;
  logic [SUM_W-1:0] cand;
  logic [31:0]      lfsr_next;
  logic             draw_hit;
  logic             scan_hit;

  // Smear every set bit downward: yields the smallest 2^k-1 covering x.
  function automatic logic [SUM_W-1:0] smear(input logic [SUM_W-1:0] x);
    logic [SUM_W-1:0] r;
    r = x;
    for (int i = 0; i < SUM_W; i++) begin
      r = r | (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    weight_ext = SUM_W'(bank[idx]);
    sum_next   = acc + weight_ext;
    cand       = lfsr[SUM_W-1:0] & mask;
    lfsr_next  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
    draw_hit   = (cand < acc);
    scan_hit   = (residual < weight_ext) || (idx == LAST_IDX);
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.in_start) state_nxt = ST_SUM;
      ST_SUM:  if (idx == LAST_IDX) state_nxt = (sum_next == '0) ? ST_DONE : ST_DRAW;
      ST_DRAW: if (draw_hit) state_nxt = ST_SCAN;
      ST_SCAN: if (scan_hit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      for (int i = 0; i < N_ITEMS; i++) begin
        bank[i] <= '0;
      end
      acc      <= '0;
      mask     <= '0;
      residual <= '0;
      idx      <= '0;
      seg      <= '0;
      err      <= 1'b0;
      lfsr     <= (bus.in_seed == 32'h0) ? 32'h1 : bus.in_seed;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.in_start) begin
            for (int i = 0; i < N_ITEMS; i++) begin
              bank[i] <= bus.in_weights[i*WIDTH +: WIDTH];
            end
            acc <= '0;
            idx <= '0;
          end
        end
        ST_SUM: begin
          acc  <= sum_next;
          mask <= smear(sum_next - SUM_W'(1));
          idx  <= idx + IDX_W'(1);
          if (idx == LAST_IDX && sum_next == '0) begin
            seg <= '0;
            err <= 1'b1;
          end
        end
        ST_DRAW: begin
          // The generator advances on every attempt, accepted or rejected.
          lfsr <= lfsr_next;
          if (draw_hit) begin
            residual <= cand;
            idx      <= '0;
          end
        end
        ST_SCAN: begin
          if (scan_hit) begin
            seg <= idx;
            err <= 1'b0;
          end else begin
            residual <= residual - weight_ext;
            idx      <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_busy           = (state != ST_IDLE);
  assign bus.out_valid          = (state == ST_DONE);
  assign bus.out_segment_number = seg;
  assign bus.out_error          = err;
endmodule
`default_nettype wire

// File: tb/tb_weighted_choose_n.sv
`timescale 1ns/1ps
`default_nettype none
//----------------------------------------------------------------------
// tb_weighted_choose_n - scoreboarded bench for weighted_choose_n, rev 1.0
//----------------------------------------------------------------------
module tb_weighted_choose_n;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int SW = W + $clog2(N) + 1;

  typedef struct {
    int idx;
    bit err;
    int lat;
    int st;
  } exp_t;

  typedef struct {
    logic [N*W-1:0] w;
    int             idx;
    bit             err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  weighted_choose_n_if #(.WIDTH(W), .N_ITEMS(N)) bus ();

  weighted_choose_n #(.WIDTH(W), .N_ITEMS(N)) dut (
    .in_clock (clk),
    .in_reset (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  exp_t        sbq[$];
  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          vcount = 0;
  int          hist[N];
  logic [31:0] m_lfsr = 32'h1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic lsb;
    lsb = s[0];
    s   = s >> 1;
    if (lsb) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  function automatic logic [N*W-1:0] one(input int i, input logic [W-1:0] v);
    logic [N*W-1:0] r;
    r = '0;
    r[i*W +: W] = v;
    return r;
  endfunction

  // Reference draw: rejection sampling on a masked LFSR window, then a linear scan.
  task automatic model_draw(input logic [N*W-1:0] w, inout logic [31:0] st,
                            output int idx, output bit err, output int lat);
    logic [31:0] sum, x, mask, cand, res;
    int          r, j;
    sum = 0;
    for (int i = 0; i < N; i++) sum = sum + 32'(w[i*W +: W]);
    if (sum == 0) begin
      idx = 0; err = 1'b1; lat = N + 1;
      return;
    end
    x    = sum - 1;
    mask = 0;
    for (int b = 0; b < SW; b++) if ((x >> b) != 0) mask[b] = 1'b1;
    r = 0;
    do begin
      cand = {12'h0, st[SW-1:0]} & mask;
      st   = lfsr_step(st);
      r++;
    end while (cand >= sum && r < 100000);
    res = cand;
    for (j = 0; j < N; j++) begin
      if (res < 32'(w[j*W +: W]) || j == N - 1) break;
      res = res - 32'(w[j*W +: W]);
    end
    idx = j; err = 1'b0; lat = N + r + j + 2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid) begin
      vcount++;
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: got valid with seg %0d, expected none", bus.out_segment_number);
      end else begin
        e = sbq.pop_front();
        chk("segment", int'(bus.out_segment_number), e.idx);
        chk("error", int'(bus.out_error), int'(e.err));
        chk("latency", cyc - e.st, e.lat);
        hist[bus.out_segment_number]++;
      end
    end
  end

  task automatic do_reset(input logic [31:0] seed);
    @(negedge clk);
    rst = 1'b1;
    bus.in_seed  = seed;
    bus.in_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", int'(bus.out_busy), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_seg", int'(bus.out_segment_number), 0);
    chk("rst_err", int'(bus.out_error), 0);
    rst = 1'b0;
    bus.in_start = 1'b0;
    m_lfsr = (seed == 0) ? 32'h1 : seed;
    @(negedge clk);
    chk("start_in_reset_ignored", int'(bus.out_busy), 0);
  endtask

  task automatic launch(input logic [N*W-1:0] w, input int fidx, input bit ferr);
    exp_t e;
    int   idx, lat;
    bit   err;
    @(negedge clk);
    bus.in_weights = w;
    bus.in_start   = 1'b1;
    model_draw(w, m_lfsr, idx, err, lat);
    e.idx = (fidx >= 0) ? fidx : idx;
    e.err = (fidx >= 0) ? ferr : err;
    e.lat = lat;
    e.st  = cyc;
    sbq.push_back(e);
    @(negedge clk);
    bus.in_start = 1'b0;
  endtask

  task automatic wait_valid(input int v0);
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk);
      if (vcount != v0) break;
    end
    if (k == 400) begin
      checks++;
      fails++;
      $display("FAIL draw_timeout: got no valid in 400 cycles, expected one");
      sbq.delete();
    end
  endtask

  task automatic draw(input logic [N*W-1:0] w, input int fidx, input bit ferr);
    int v0;
    v0 = vcount;
    launch(w, fidx, ferr);
    wait_valid(v0);
  endtask

  localparam logic [N*W-1:0] DIST_W =
    {16'd4, 16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd1};

  initial begin
    #1_200_000;
    fails++;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    vec_t        tbl[8];
    logic [31:0] tmp;
    int          idx, lat, r, s, v0, k, total;
    bit          err;

    bus.in_start   = 1'b0;
    bus.in_weights = '0;
    bus.in_seed    = 32'h0;

    tbl[0] = '{one(0, 16'd1),      0,  1'b0};
    tbl[1] = '{one(7, 16'hFFFF),   7,  1'b0};
    tbl[2] = '{one(3, 16'd2),      3,  1'b0};
    tbl[3] = '{'0,                 0,  1'b1};
    tbl[4] = '{DIST_W,             -1, 1'b0};
    tbl[5] = '{one(6, 16'd100),    6,  1'b0};
    tbl[6] = '{{N{16'hFFFF}},      -1, 1'b0};
    tbl[7] = '{one(7, 16'd1) | one(0, 16'hFFFF), -1, 1'b0};

    do_reset(32'h1234);
    for (int i = 0; i < 8; i++) draw(tbl[i].w, tbl[i].idx, tbl[i].err);

    do_reset(32'h1234);
    for (int i = 0; i < 100; i++) draw(one(5, 16'd7), 5, 1'b0);

    // Start asserted in the DONE cycle must not launch a second draw.
    v0 = vcount;
    launch(one(2, 16'd9), 2, 1'b0);
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    bus.in_start = 1'b1;
    @(negedge clk);
    bus.in_start = 1'b0;
    chk("start_in_done_ignored", int'(bus.out_busy), 0);
    repeat (30) @(negedge clk);
    chk("done_start_valid_count", vcount - v0, 1);

    // Start pulses and weight churn while busy.
    v0 = vcount;
    launch(one(5, 16'd7), 5, 1'b0);
    for (int i = 0; i <= N; i++) begin
      @(negedge clk);
      bus.in_start   = 1'b1;
      bus.in_weights = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    bus.in_start   = 1'b0;
    bus.in_weights = '0;
    wait_valid(v0);
    repeat (40) @(negedge clk);
    chk("busy_one_valid", vcount - v0, 1);
    chk("busy_queue_empty", sbq.size(), 0);

    // Reset pulse in the middle of SCAN aborts the draw.
    tmp = m_lfsr;
    model_draw(one(7, 16'd5), tmp, idx, err, lat);
    r = lat - N - idx - 2;
    @(negedge clk);
    bus.in_weights = one(7, 16'd5);
    bus.in_start   = 1'b1;
    s = cyc;
    @(negedge clk);
    bus.in_start = 1'b0;
    while (cyc < s + N + r + 3) @(negedge clk);
    rst = 1'b1;
    bus.in_seed = 32'hBEEF;
    v0 = vcount;
    @(negedge clk);
    rst = 1'b0;
    chk("midscan_busy", int'(bus.out_busy), 0);
    chk("midscan_valid", int'(bus.out_valid), 0);
    chk("midscan_seg", int'(bus.out_segment_number), 0);
    chk("midscan_err", int'(bus.out_error), 0);
    m_lfsr = 32'hBEEF;
    repeat (30) @(negedge clk);
    chk("midscan_no_valid", vcount - v0, 0);
    for (int i = 0; i < 10; i++) draw(DIST_W, -1, 1'b0);

    // Seed zero behaves as seed one.
    do_reset(32'h0);
    for (int i = 0; i < 20; i++) draw(DIST_W, -1, 1'b0);
    do_reset(32'h1);
    for (int i = 0; i < 20; i++) draw(DIST_W, -1, 1'b0);

    do_reset(32'hACE1);
    for (int i = 0; i < N; i++) hist[i] = 0;
    total = 3000;
    for (int i = 0; i < total; i++) draw(DIST_W, -1, 1'b0);
    chk_range("dist_item0_permille", hist[0] * 1000 / total, 95, 155);
    chk_range("dist_item3_permille", hist[3] * 1000 / total, 345, 405);
    chk_range("dist_item7_permille", hist[7] * 1000 / total, 470, 530);
    chk("dist_item1", hist[1], 0);
    chk("dist_item2", hist[2], 0);
    chk("dist_item4", hist[4], 0);
    chk("dist_item5", hist[5], 0);
    chk("dist_item6", hist[6], 0);
    chk("final_queue_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
`default_nettype wire
